// File: rtl/equiv_checker.sv
// equiv_checker
//   Sweeps every NIN-bit input vector of two candidate combinational circuits
//   in ascending order. After each vector is applied it waits SETTLE idle
//   cycles, then samples and compares the two responses. It counts the
//   mismatching vectors and reports a pass/fail verdict.
//
// Parameters
//   NIN    : number of stimulus inputs (1..8)
//   SETTLE : idle cycles between applying a vector and sampling it (0..15)
//
// Ports
//   clk, rst         : clock; asynchronous active-high reset
//   i_start          : requests a sweep; only honoured in IDLE
//   i_resp_a/b       : responses of candidate circuits A and B
//   o_stim           : stimulus vector driven to both candidates
//   o_busy           : a sweep is in progress
//   o_done           : one-cycle pulse; the verdict is valid
//   o_equal          : no mismatch occurred in the last sweep
//   o_mismatch_cnt   : mismatching vectors in the last or current sweep
//   o_fail_valid/vec : first failing vector (EQUIV_FAIL_CAPTURE_EN only)
//
// Build option
//   EQUIV_FAIL_CAPTURE_EN : adds the first-failure capture ports and logic.
module equiv_checker #(
  parameter int NIN    = 2,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_resp_a,
  input  logic           i_resp_b,
  output logic [NIN-1:0] o_stim,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_equal,
  output logic [NIN:0]   o_mismatch_cnt
`ifdef EQUIV_FAIL_CAPTURE_EN
  ,
  output logic           o_fail_valid,
  output logic [NIN-1:0] o_fail_vec
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  // With no settle time the sweep never visits WAIT.
  localparam bit NO_WAIT = (SETTLE == 0);

  state_t         r_state, w_next;
  logic [3:0]     r_settle;
  logic [NIN-1:0] r_stim;
  logic [NIN:0]   r_cnt;
  logic           r_busy, r_done, r_equal;
  logic           w_accept, w_last, w_mis;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = &r_stim;
  assign w_mis    = i_resp_a ^ i_resp_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = NO_WAIT ? S_SAMPLE : S_WAIT;
      // The counter is loaded with SETTLE, so the last WAIT cycle sees 1.
      S_WAIT:   if (r_settle == 4'd1) w_next = S_SAMPLE;
      S_SAMPLE: begin
        if (w_last)       w_next = S_DONE;
        else if (NO_WAIT) w_next = S_SAMPLE;
        else              w_next = S_WAIT;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
      r_stim   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_equal  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_stim   <= '0;
          r_cnt    <= '0;
          r_equal  <= 1'b0;
          r_busy   <= 1'b1;
          r_settle <= SETTLE_L;
        end
        S_WAIT: r_settle <= r_settle - 4'd1;
        S_SAMPLE: begin
          if (w_mis) r_cnt <= r_cnt + (NIN+1)'(1);
          if (!w_last) begin
            r_stim   <= r_stim + NIN'(1);
            r_settle <= SETTLE_L;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_equal <= (r_cnt == '0);
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_stim         = r_stim;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_equal        = r_equal;
  assign o_mismatch_cnt = r_cnt;

`ifdef EQUIV_FAIL_CAPTURE_EN
  logic           r_fail_valid;
  logic [NIN-1:0] r_fail_vec;

  // Only the first mismatch of a sweep is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_accept) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (r_state == S_SAMPLE && w_mis && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_vec   <= r_stim;
    end
  end

  assign o_fail_valid = r_fail_valid;
  assign o_fail_vec   = r_fail_vec;
`endif

endmodule

// File: tb/tb_equiv_checker.sv
module tb_equiv_checker;

  localparam int N0 = 2, S0 = 1;  // default configuration
  localparam int N1 = 3, S1 = 0;  // wider, zero-settle configuration

  typedef struct {
    int done_cyc;
    int cnt;
    int eq;
    int fv;
    int fvec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Candidate circuits are truth tables indexed by the stimulus.
  logic [255:0] ta0, tb0, ta1, tb1;
  logic          i_start0, i_start1;
  logic [N0-1:0] stim0;
  logic [N1-1:0] stim1;
  logic          busy0, busy1, done0, done1, eq0, eq1;
  logic [N0:0]   cnt0;
  logic [N1:0]   cnt1;
  int            fv0_i, fvec0_i, fv1_i, fvec1_i;
`ifdef EQUIV_FAIL_CAPTURE_EN
  logic          fv0, fv1;
  logic [N0-1:0] fvec0;
  logic [N1-1:0] fvec1;
  assign fv0_i = int'(fv0); assign fvec0_i = int'(fvec0);
  assign fv1_i = int'(fv1); assign fvec1_i = int'(fvec1);
`else
  assign fv0_i = 0; assign fvec0_i = 0;
  assign fv1_i = 0; assign fvec1_i = 0;
`endif

  equiv_checker #(.NIN(N0), .SETTLE(S0)) u0 (
    .clk(clk), .rst(rst), .i_start(i_start0),
    .i_resp_a(ta0[stim0]), .i_resp_b(tb0[stim0]),
    .o_stim(stim0), .o_busy(busy0), .o_done(done0), .o_equal(eq0),
    .o_mismatch_cnt(cnt0)
`ifdef EQUIV_FAIL_CAPTURE_EN
    , .o_fail_valid(fv0), .o_fail_vec(fvec0)
`endif
  );

  equiv_checker #(.NIN(N1), .SETTLE(S1)) u1 (
    .clk(clk), .rst(rst), .i_start(i_start1),
    .i_resp_a(ta1[stim1]), .i_resp_b(tb1[stim1]),
    .o_stim(stim1), .o_busy(busy1), .o_done(done1), .o_equal(eq1),
    .o_mismatch_cnt(cnt1)
`ifdef EQUIV_FAIL_CAPTURE_EN
    , .o_fail_valid(fv1), .o_fail_vec(fvec1)
`endif
  );

  exp_t q0[$], q1[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: walk the truth tables directly.
  function automatic exp_t model(input int n, input int settle, input int k,
                                 input logic [255:0] a, input logic [255:0] b);
    exp_t e;
    e.cnt = 0; e.fv = 0; e.fvec = 0;
    for (int v = 0; v < (1 << n); v++)
      if (a[v] != b[v]) begin
        e.cnt++;
        if (e.fv == 0) begin e.fv = 1; e.fvec = v; end
      end
    e.eq = (e.cnt == 0) ? 1 : 0;
    e.done_cyc = k + (1 << n) * (settle + 1) + 1;
    return e;
  endfunction

  task automatic on_done(input string p, input int n, input exp_t e, input int c,
                         input int cnt, input int eq, input int bsy, input int stim,
                         input int fv, input int fvec);
    chk({p, "_done_cycle"}, c, e.done_cyc);
    chk({p, "_mismatch_cnt"}, cnt, e.cnt);
    chk({p, "_equal"}, eq, e.eq);
    chk({p, "_busy_at_done"}, bsy, 0);
    chk({p, "_stim_hold"}, stim, (1 << n) - 1);
`ifdef EQUIV_FAIL_CAPTURE_EN
    chk({p, "_fail_valid"}, fv, e.fv);
    if (e.fv != 0) chk({p, "_fail_vec"}, fvec, e.fvec);
`endif
  endtask

  exp_t m0, m1;
  always @(negedge clk) if (!rst) begin
    if (done0) begin
      if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
      else begin
        m0 = q0.pop_front();
        on_done("u0", N0, m0, cyc, int'(cnt0), int'(eq0), int'(busy0), int'(stim0), fv0_i, fvec0_i);
      end
    end else if (q0.size() > 0 && cyc > q0[0].done_cyc) begin
      chk("u0_done_timeout", cyc, q0[0].done_cyc);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) if (!rst) begin
    if (done1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else begin
        m1 = q1.pop_front();
        on_done("u1", N1, m1, cyc, int'(cnt1), int'(eq1), int'(busy1), int'(stim1), fv1_i, fvec1_i);
      end
    end else if (q1.size() > 0 && cyc > q1[0].done_cyc) begin
      chk("u1_done_timeout", cyc, q1[0].done_cyc);
      void'(q1.pop_front());
    end
  end

  task automatic drain();
    int g = 0;
    while ((q0.size() > 0 || q1.size() > 0) && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) chk("drain_timeout", g, 0);
  endtask

  // Issue one start on DUT id once it is idle; returns just after acceptance.
  task automatic sweep(input int id, input logic [255:0] a, input logic [255:0] b,
                       input bit wait_done);
    int g = 0;
    @(negedge clk);
    while (((id == 0) ? busy0 : busy1) && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("idle_timeout", g, 0);
    if (id == 0) begin
      ta0 = a; tb0 = b; i_start0 = 1'b1;
      q0.push_back(model(N0, S0, cyc + 1, a, b));
    end else begin
      ta1 = a; tb1 = b; i_start1 = 1'b1;
      q1.push_back(model(N1, S1, cyc + 1, a, b));
    end
    @(negedge clk);
    i_start0 = 1'b0; i_start1 = 1'b0;
    if (id == 0) begin
      chk("u0_busy_after_start", int'(busy0), 1);
      chk("u0_stim_after_start", int'(stim0), 0);
      chk("u0_cnt_after_start", int'(cnt0), 0);
    end else begin
      chk("u1_busy_after_start", int'(busy1), 1);
      chk("u1_cnt_after_start", int'(cnt1), 0);
    end
    if (wait_done) drain();
  endtask

  task automatic chk_reset_state(input string p);
    chk({p, "_stim0"}, int'(stim0), 0);  chk({p, "_busy0"}, int'(busy0), 0);
    chk({p, "_done0"}, int'(done0), 0);  chk({p, "_equal0"}, int'(eq0), 0);
    chk({p, "_cnt0"}, int'(cnt0), 0);    chk({p, "_stim1"}, int'(stim1), 0);
    chk({p, "_busy1"}, int'(busy1), 0);  chk({p, "_cnt1"}, int'(cnt1), 0);
`ifdef EQUIV_FAIL_CAPTURE_EN
    chk({p, "_fail_valid0"}, fv0_i, 0);  chk({p, "_fail_vec0"}, fvec0_i, 0);
`endif
  endtask

  initial begin
    logic [255:0] nand2, nor2, a, b;
    int k;
    nand2 = '0; nand2[3:0] = 4'b0111;
    nor2  = '0; nor2[3:0]  = 4'b0001;
    ta0 = '0; tb0 = '0; ta1 = '0; tb1 = '0;
    i_start0 = 1'b0; i_start1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // De Morgan: NAND vs OR of inverted inputs (same table).
    sweep(0, nand2, nand2, 1);
    // NAND vs NOR: mismatches at 01 and 10.
    sweep(0, nand2, nor2, 1);
    // stim[0] vs ~stim[0] on 3 inputs: every vector mismatches.
    a = '0; a[7:0] = 8'hAA; b = '0; b[7:0] = 8'h55;
    sweep(1, a, b, 1);

    // Start re-pulsed mid-sweep is ignored.
    sweep(0, nand2, nor2, 0);
    repeat (2) @(negedge clk);
    i_start0 = 1'b1;
    @(negedge clk);
    i_start0 = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset at edge k+5 of a default sweep.
    sweep(0, nand2, nor2, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_state("midsweep_rst");
    q0.delete(); q1.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    sweep(0, nand2, nor2, 1);

    // Start held high: back-to-back sweeps, counter cleared at each accept.
    @(negedge clk);
    ta0 = nand2; tb0 = nor2; i_start0 = 1'b1;
    k = cyc + 1;
    for (int s = 0; s < 3; s++) q0.push_back(model(N0, S0, k + 10 * s, nand2, nor2));
    while (cyc < k + 10) @(negedge clk);
    chk("b2b_cnt_cleared_1", int'(cnt0), 0);
    chk("b2b_busy_1", int'(busy0), 1);
    while (cyc < k + 20) @(negedge clk);
    chk("b2b_cnt_cleared_2", int'(cnt0), 0);
    while (cyc < k + 29) @(negedge clk);
    i_start0 = 1'b0;
    drain();

    // Random truth tables on both configurations, running concurrently.
    for (int r = 0; r < 12; r++) begin
      a = '0; b = '0;
      a[31:0] = $urandom();
      b[31:0] = ($urandom_range(0, 2) == 0) ? a[31:0] : $urandom();
      sweep(r % 2, a, b, (r % 4) == 3);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/equiv_checker.md
# equiv_checker

Sequential truth-table equivalence checker for small combinational gate networks. It sweeps every input combination of two candidate circuits in ascending binary order, waits a programmable settle time per vector, and compares the two returned outputs. It counts mismatches and reports a pass/fail verdict. It is the response-checking end of the gate-equivalence flow: it drives the stimulus bus and consumes the circuits' outputs, so De Morgan and universal-gate equivalences can be proven in hardware.

## Interface
- NIN, default 2: number of stimulus inputs, legal range 1..8.
- SETTLE, default 1: idle cycles after applying each vector before sampling, legal range 0..15.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- stim  output  NIN  stimulus vector driven to both candidate circuits.
- resp_a  input  1  output of candidate circuit A.
- resp_b  input  1  output of candidate circuit B.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse marking verdict valid.
- equal  output  1  verdict: 1 when no mismatch occurred in the last sweep.
- mismatch_cnt  output  NIN+1  number of mismatching vectors in the last or current sweep.
- fail_valid, fail_vec  output  1, NIN  first failing vector; present only with the configuration macro.

## Operation
- Reset values:
  - stim=0, busy=0, done=0, equal=0, mismatch_cnt=0.
  - fail_valid=0, fail_vec=0.
  - State IDLE.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - On start=1, load stim=0, mismatch_cnt=0, equal=0, fail_valid=0, and set busy=1.
  - Load the settle counter with SETTLE.
  - Go to WAIT, or go directly to SAMPLE if SETTLE=0.
- WAIT: decrement the settle counter. At 0, go to SAMPLE.
- SAMPLE:
  - If resp_a != resp_b, increment mismatch_cnt.
  - If stim is all ones, go to DONE.
  - Otherwise stim <= stim+1, reload the settle counter, and go to WAIT (or stay in SAMPLE when SETTLE=0).
- DONE:
  - done=1 for exactly one cycle.
  - equal <= (final mismatch_cnt == 0); busy <= 0.
  - Return to IDLE.
- stim holds its last value (all ones) after the sweep until the next start.
- equal and mismatch_cnt hold until the next accepted start.
- start is ignored while busy=1 or in DONE. No queuing.
- mismatch_cnt width NIN+1 covers the maximum count 2^NIN without overflow. No wrap is possible.
- resp_a/resp_b are assumed to be 0/1 and stable by the sampling edge. X/Z behaviour is unspecified.
- Asynchronous rst mid-sweep immediately forces all reset values and abandons the sweep. No done pulse is produced.

## Timing
- Start accepted at edge k. stim=0 is valid after edge k.
- Sampling of vector i occurs at edge k+(i+1)(SETTLE+1).
- Last sample at edge k+2^NIN*(SETTLE+1). done is high during the following cycle.
  - Defaults (NIN=2, SETTLE=1): samples at edges k+2, k+4, k+6, k+8; done high after edge k+9.
  - SETTLE=0, NIN=2: done high after edge k+5.
- A new start can be accepted on the first cycle back in IDLE, i.e. the cycle after done.

## Configuration
- EQUIV_FAIL_CAPTURE_EN defined:
  - fail_valid and fail_vec ports exist.
  - On the first mismatching SAMPLE of a sweep, fail_vec <= stim and fail_valid <= 1.
  - Later mismatches do not overwrite the capture. Both are cleared on an accepted start or on rst.
- EQUIV_FAIL_CAPTURE_EN undefined: the ports and capture logic are absent. All other behaviour is identical.

## Test plan
- NAND of stim vs. OR of inverted stim (De Morgan), defaults -> done after edge k+9, equal=1, mismatch_cnt=0, fail_valid=0.
- NAND vs. NOR, defaults -> mismatches at stim=01 and 10, mismatch_cnt=2, equal=0, fail_vec=01 with capture enabled.
- resp_a=stim[0], resp_b=~stim[0], NIN=3, SETTLE=0 -> mismatch_cnt=8 (full count, no wrap), done high after edge k+9.
- start pulsed again 3 cycles into a sweep -> ignored; sweep completes on original schedule with a single done pulse.
- rst asserted at edge k+5 of a default sweep -> all outputs return to reset values at once, no done; a fresh start then completes normally.
- Back-to-back sweeps: start held high continuously -> a new sweep begins the cycle after each done, with mismatch_cnt cleared at each accepted start.
